// File: rtl/train_pkg.sv
// Shared train-control definitions: sensor count, default timing constants
// and the sensor vector type used by the conditioner and the control FSM.
package train_pkg;

  localparam int unsigned NUM_SENSORS             = 4;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEFAULT_STUCK_CYCLES    = 1048576;

  typedef logic [NUM_SENSORS:1] sensor_vec_t;

  // Debounce counter width; a single flop when only one cycle is needed.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Sensor bus between the raw track sensors and the train-control FSM.
//   SR_RAW  : raw asynchronous sensor lines (1 = train present)
//   SR      : debounced sensor levels
//   SR_RISE : one-cycle pulse on each debounced 0->1 arrival
//   FAULT   : sticky stuck-sensor flags
// master = sensor/stimulus side, slave = conditioner side.
interface sensor_conditioner_if;
  import train_pkg::*;

  sensor_vec_t SR_RAW;
  sensor_vec_t SR;
  sensor_vec_t SR_RISE;
  sensor_vec_t FAULT;

  modport master (output SR_RAW, input SR, SR_RISE, FAULT);
  modport slave  (input SR_RAW, output SR, SR_RISE, FAULT);
endinterface

// File: rtl/sensor_debounce_ch.sv
// One sensor channel: two-flop synchroniser, debounce counter, registered
// rise pulse and, with SENSOR_STUCK_DETECT_EN defined, a sticky stuck flag.
// Ports:
//   Clock, RESET : clock, synchronous active-high reset
//   sr_raw       : raw asynchronous sensor line
//   sr           : debounced level
//   sr_rise      : one-cycle pulse on the debounced 0->1 edge
//   fault        : sticky stuck flag (constant 0 when compiled out)
module sensor_debounce_ch
  import train_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEFAULT_STUCK_CYCLES
) (
  input  logic Clock,
  input  logic RESET,
  input  logic sr_raw,
  output logic sr,
  output logic sr_rise,
  output logic fault
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             done_c;
  logic             sr_next_c;

  // The new value has disagreed with sr for DEBOUNCE_CYCLES edges, this one included.
  assign done_c    = (s2 != sr) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign sr_next_c = done_c ? s2 : sr;

  // Synchroniser, debounce counter, level and rise pulse.
  always_ff @(posedge Clock) begin
    if (RESET) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      sr      <= 1'b0;
      sr_rise <= 1'b0;
    end else begin
      s1      <= sr_raw;
      s2      <= s1;
      sr      <= sr_next_c;
      sr_rise <= done_c & s2;
      if ((s2 == sr) || done_c) cnt <= '0;
      else                      cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef SENSOR_STUCK_DETECT_EN
  localparam int unsigned HOLD_W = $clog2(STUCK_CYCLES + 1);

  logic [HOLD_W-1:0] hold;

  // hold counts edges with the (updated) level high, so the rise edge counts as 1.
  always_ff @(posedge Clock) begin
    if (RESET) begin
      hold  <= '0;
      fault <= 1'b0;
    end else begin
      if (!sr_next_c)                             hold <= '0;
      else if (hold != HOLD_W'(STUCK_CYCLES))     hold <= hold + HOLD_W'(1);
      if (sr_next_c && (hold == HOLD_W'(STUCK_CYCLES - 1))) fault <= 1'b1;
    end
  end
`else
  logic unused_stuck_cycles;

  assign unused_stuck_cycles = (STUCK_CYCLES == 0);
  assign fault               = 1'b0;
`endif

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the four raw track-occupancy sensors for the train-control FSM:
// per-channel synchronise, debounce, rise pulse and optional stuck detection.
// Optional feature macro: SENSOR_STUCK_DETECT_EN (FAULT tied to 0 when undefined).
// Ports:
//   Clock, RESET : clock, synchronous active-high reset
//   bus (slave)  : SR_RAW in; SR, SR_RISE, FAULT out
module sensor_conditioner
  import train_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEFAULT_STUCK_CYCLES
) (
  input  logic                 Clock,
  input  logic                 RESET,
  sensor_conditioner_if.slave  bus
);

  sensor_vec_t sr_v;
  sensor_vec_t rise_v;
  sensor_vec_t fault_v;

  // Independent identical channels.
  for (genvar i = 1; i <= NUM_SENSORS; i++) begin : g_ch
    sensor_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ch (
      .Clock   (Clock),
      .RESET   (RESET),
      .sr_raw  (bus.SR_RAW[i]),
      .sr      (sr_v[i]),
      .sr_rise (rise_v[i]),
      .fault   (fault_v[i])
    );
  end

  assign bus.SR      = sr_v;
  assign bus.SR_RISE = rise_v;
  assign bus.FAULT   = fault_v;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed latency scenarios plus randomized
// bouncy stimulus, compared every cycle against a sample-window reference model.
module tb_sensor_conditioner;
  import train_pkg::*;

  localparam int unsigned DEB   = 4;
  localparam int unsigned STUCK = 32;

  logic Clock;
  logic RESET;

  sensor_conditioner_if bus ();

  sensor_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .STUCK_CYCLES    (STUCK)
  ) dut (
    .Clock (Clock),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: raw is seen two edges late; the level flips once the
  // last DEB synchronised samples all disagree with it.
  logic [DEB-1:0] hist [1:4];
  int             fill [1:4];
  int             high_since [1:4];
  logic [4:1]     m_s1, m_s2, m_sr, m_rise, m_fault;
  int             edge_n = 0;

  always @(posedge Clock) begin
    edge_n++;
    if (RESET) begin
      m_s1 = '0; m_s2 = '0; m_sr = '0; m_rise = '0; m_fault = '0;
      for (int i = 1; i <= 4; i++) begin
        hist[i] = '0; fill[i] = 0; high_since[i] = 0;
      end
    end else begin
      for (int i = 1; i <= 4; i++) begin
        hist[i] = DEB'({hist[i], m_s2[i]});
        fill[i]++;
        m_rise[i] = 1'b0;
        if (fill[i] >= DEB && hist[i] == {DEB{~m_sr[i]}}) begin
          m_sr[i]   = ~m_sr[i];
          m_rise[i] = m_sr[i];
          if (m_sr[i]) high_since[i] = edge_n;
        end
`ifdef SENSOR_STUCK_DETECT_EN
        if (m_sr[i] && (edge_n - high_since[i] + 1) >= STUCK) m_fault[i] = 1'b1;
`endif
      end
      m_s2 = m_s1;
      m_s1 = bus.SR_RAW;
    end
  end

  // Continuous comparison away from the active edge.
  always @(negedge Clock) begin
    if (chk_en) begin
      check_eq("SR",      32'(bus.SR),      32'(m_sr));
      check_eq("SR_RISE", 32'(bus.SR_RISE), 32'(m_rise));
      check_eq("FAULT",   32'(bus.FAULT),   32'(m_fault));
    end
  end

  // Counts edges (first edge after the call is offset start+1) until SR&mask==val.
  task automatic wait_sr(input logic [4:1] mask, input logic [4:1] val,
                         input int start, output int off);
    off = start;
    for (int n = 0; n < 60; n++) begin
      @(posedge Clock);
      off++;
      #1;
      if ((bus.SR & mask) == val) return;
    end
    check_eq("wait_sr_timeout", 32'(bus.SR & mask), 32'(val));
    off = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  int lat;
  logic [4:1] raw;
  int left [1:4];
  logic exp_fault;

  initial begin
`ifdef SENSOR_STUCK_DETECT_EN
    exp_fault = 1'b1;
`else
    exp_fault = 1'b0;
`endif
    // Scenario 1: reset with all sensors high, then qualify.
    RESET      = 1'b1;
    bus.SR_RAW = 4'b1111;
    @(posedge Clock);
    chk_en = 1'b1;
    idle(3);
    RESET = 1'b0;
    wait_sr(4'b1111, 4'b1111, -1, lat);
    check_eq("s1_latency", 32'(lat), 32'd5);
    check_eq("s1_rise", 32'(bus.SR_RISE), 32'hF);
    @(negedge Clock);
    bus.SR_RAW = 4'b0000;
    idle(12);

    // Scenario 2: 3-cycle glitch ignored, 4-cycle pulse passes.
    bus.SR_RAW[1] = 1'b1; idle(3); bus.SR_RAW[1] = 1'b0;
    idle(10);
    check_eq("s2_glitch_sr", 32'(bus.SR[1]), 32'd0);
    bus.SR_RAW[1] = 1'b1;
    wait_sr(4'b0001, 4'b0001, -1, lat);
    check_eq("s2_pulse_latency", 32'(lat), 32'd5);
    @(negedge Clock);
    bus.SR_RAW[1] = 1'b0;
    idle(12);

    // Scenario 3: bounce 1,0,1,1,1,1 restarts the count.
    bus.SR_RAW[2] = 1'b1; idle(1);
    bus.SR_RAW[2] = 1'b0; idle(1);
    bus.SR_RAW[2] = 1'b1;
    wait_sr(4'b0010, 4'b0010, 1, lat);
    check_eq("s3_bounce_latency", 32'(lat), 32'd7);
    @(negedge Clock);
    bus.SR_RAW[2] = 1'b0;
    idle(12);

    // Scenario 4: two channels rising together.
    bus.SR_RAW[4:3] = 2'b11;
    wait_sr(4'b1100, 4'b1100, -1, lat);
    check_eq("s4_latency", 32'(lat), 32'd5);
    check_eq("s4_rise", 32'(bus.SR_RISE[4:3]), 32'd3);
    @(posedge Clock); #1;
    check_eq("s4_rise_clear", 32'(bus.SR_RISE[4:3]), 32'd0);
    @(negedge Clock);
    bus.SR_RAW[4:3] = 2'b00;
    idle(12);

    // Scenario 5: stuck sensor, sticky until reset.
    bus.SR_RAW[1] = 1'b1;
    idle(8 + STUCK);
    check_eq("s5_fault_set", 32'(bus.FAULT[1]), 32'(exp_fault));
    bus.SR_RAW[1] = 1'b0;
    idle(12);
    check_eq("s5_fault_sticky", 32'(bus.FAULT[1]), 32'(exp_fault));
    check_eq("s5_sr_fell", 32'(bus.SR[1]), 32'd0);
    RESET = 1'b1; idle(1); RESET = 1'b0;
    check_eq("s5_fault_cleared", 32'(bus.FAULT), 32'd0);
    idle(4);

    // Scenario 6: reset when the debounce count is 2 discards progress.
    bus.SR_RAW = 4'b1111;
    idle(4);
    RESET = 1'b1; idle(1); RESET = 1'b0;
    check_eq("s6_sr_after_reset", 32'(bus.SR), 32'd0);
    wait_sr(4'b1111, 4'b1111, -1, lat);
    check_eq("s6_latency", 32'(lat), 32'd5);
    @(negedge Clock);
    bus.SR_RAW = 4'b0000;
    idle(12);

    // Randomized bouncy traffic with occasional long holds and resets.
    raw = '0;
    for (int i = 1; i <= 4; i++) left[i] = 0;
    repeat (3000) begin
      @(negedge Clock);
      for (int i = 1; i <= 4; i++) begin
        if (left[i] == 0) begin
          raw[i]  = 1'($urandom_range(0, 1));
          left[i] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(35, 50))
                                                 : int'($urandom_range(1, 8));
        end else begin
          left[i]--;
        end
      end
      bus.SR_RAW = raw;
      RESET      = ($urandom_range(0, 299) == 0);
    end
    @(negedge Clock);
    RESET = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
